multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle MIPS control unit: Moore FSM sequencing a shared-ALU, shared-memory datapath (PC, IR, MDR, A/B, ALUOut registers).
- Decodes opcode/funct and emits per-cycle datapath controls.
- Stalls on a memory-ready handshake and counts retired instructions.
- Replaces the combinational single-cycle controller when the core is built multicycle.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memRead  output  1  memory read strobe
- memWrite  output  1  memory write strobe
- irWrite  output  1  load IR
- regdst  output  1  write reg select: 0=rt, 1=rd
- memtoReg  output  1  write-back data select: 0=ALUOut, 1=MDR
- regWrite  output  1  register file write
- aluSrcA  output  1  ALU A select: 0=PC, 1=A
- aluSrcB  output  2  ALU B select: 00=B, 01=4, 10=ext(imm), 11=sext(imm)<<2
- extOp  output  1  immediate extension: 0=sign, 1=zero
- aluControl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- pcSrc  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
- pcEn  output  1  PC load enable
- illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode/funct
- state  output  4  current state, for debug
- instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, instr_count=0.
  - All outputs take FETCH decode with mem_ready treated as 0: memRead=1, pcEn=0, irWrite=0, all write enables 0.
- Unlisted outputs are 0 in every state.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11
  - Codes 12-15 are unreachable and go to FETCH.
- FETCH:
  - Drives iord=0, memRead=1, aluSrcA=0, aluSrcB=01, aluControl=ADD, pcSrc=00.
  - irWrite=pcEn=mem_ready.
  - Stays in FETCH while mem_ready=0; on mem_ready=1 goes to DECODE.
- DECODE:
  - Drives aluSrcA=0, aluSrcB=11, ADD (branch target into ALUOut).
  - Next state by opcode: lw/sw(100011/101011)->MEMADR, R-type(000000)->EXEC, beq(000100)->BRANCH, addi/andi/ori/slti(001000/001100/001101/001010)->IMMEX, j(000010)->JUMP.
  - Any other opcode, or R-type with funct not in {100000,100010,100100,100101,101010}: illegal=1 for this cycle, next=FETCH, no writes, counter unchanged.
- MEMADR: aluSrcA=1, aluSrcB=10, extOp=0, ADD; next MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1, memRead=1; holds until mem_ready=1, then MEMWB.
- MEMWB: regdst=0, memtoReg=1, regWrite=1; next FETCH; retires.
- MEMWR: iord=1, memWrite=1 held until mem_ready=1; then next FETCH and retire.
- EXEC: aluSrcA=1, aluSrcB=00, aluControl from funct (add->ADD, sub->SUB, and->AND, or->OR, slt->SLT); next ALUWB.
- ALUWB: regdst=1, memtoReg=0, regWrite=1; next FETCH; retires.
- BRANCH:
  - aluSrcA=1, aluSrcB=00, SUB, pcSrc=01, pcEn=zero (Mealy on zero).
  - Next FETCH; retires regardless of zero.
- IMMEX:
  - aluSrcA=1, aluSrcB=10.
  - addi: ADD, extOp=0. andi: AND, extOp=1. ori: OR, extOp=1. slti: SLT, extOp=0.
  - Next IMMWB.
- IMMWB: regdst=0, memtoReg=0, regWrite=1; next FETCH; retires.
- JUMP: pcSrc=10, pcEn=1; next FETCH; retires.
- Instruction mix latencies (mem_ready always 1):
  - lw 5 cycles; sw, R-type, immediates 4; beq and j 3.
  - Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Retire:
  - instr_count increments by 1 on the clock edge leaving MEMWB, ALUWB, IMMWB, BRANCH, JUMP, or MEMWR with mem_ready=1.
  - Wraps modulo 2^CNT_W.
- opcode/funct are sampled only in DECODE/EXEC/IMMEX/MEMADR; the IR holds them stable after irWrite.
- rst_n asserted mid-instruction: immediate return to FETCH; the pending write is dropped and the counter is cleared.

Test Plan:
- Reset with rst_n=0 then release, mem_ready=1 -> state=0, memRead=1, irWrite=1, pcEn=1 in the first cycle; instr_count=0.
- lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; regWrite=1 with memtoReg=1 only in state 4; instr_count 0->1.
- sw with mem_ready low for 3 cycles in MEMWR -> memWrite=1 for 4 cycles, iord=1; count increments once; no regWrite at any point.
- beq: zero=1 -> pcEn=1 with pcSrc=01 in BRANCH; zero=0 -> pcEn=0; both retire in 3 cycles.
- andi then slti -> IMMEX shows aluControl=0000 with extOp=1, then aluControl=0111 with extOp=0; R-type sub (funct 100010) -> EXEC aluControl=0110, ALUWB regdst=1.
- opcode 111111, and R-type with funct 000000 -> illegal=1 for one cycle in DECODE, return to FETCH, no regWrite/memWrite, count unchanged; rst_n pulsed in state 3 -> state=0 asynchronously.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore sequencer for a shared-ALU/shared-memory datapath,
// with memory-ready stalls and a retired-instruction counter.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regdst,
    output logic             memtoReg,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic             extOp,
    output logic [3:0]       aluControl,
    output logic [1:0]       pcSrc,
    output logic             pcEn,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             funct_ok;

    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);

    always_comb begin
        state_d    = S_FETCH;
        retire     = 1'b0;
        iord       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regdst     = 1'b0;
        memtoReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        extOp      = 1'b0;
        aluControl = ALU_AND;
        pcSrc      = 2'b00;
        pcEn       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // While reset is held, the fetch must not load IR or PC.
                memRead    = 1'b1;
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
                irWrite    = mem_ready & rst_n;
                pcEn       = mem_ready & rst_n;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcB    = 2'b11;
                aluControl = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:                       state_d = S_MEMADR;
                    OP_BEQ:                             state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMMEX;
                    OP_J:                               state_d = S_JUMP;
                    OP_RTYPE: begin
                        state_d = funct_ok ? S_EXEC : S_FETCH;
                        illegal = ~funct_ok;
                    end
                    default:                            illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                state_d    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memRead = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memWrite = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    FN_SUB:  aluControl = ALU_SUB;
                    FN_AND:  aluControl = ALU_AND;
                    FN_OR:   aluControl = ALU_OR;
                    FN_SLT:  aluControl = ALU_SLT;
                    default: aluControl = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcSrc      = 2'b01;
                pcEn       = zero;
                retire     = 1'b1;
            end
            S_IMMEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = S_IMMWB;
                case (opcode)
                    OP_ANDI: begin aluControl = ALU_AND; extOp = 1'b1; end
                    OP_ORI:  begin aluControl = ALU_OR;  extOp = 1'b1; end
                    OP_SLTI: aluControl = ALU_SLT;
                    default: aluControl = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
            end
            S_JUMP: begin
                pcSrc  = 2'b10;
                pcEn   = 1'b1;
                retire = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: expected state sequences are queued per
// instruction and popped each cycle alongside inline checks of the control outputs.
module tb_multicycle_controller;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             iord, memRead, memWrite, irWrite, regdst, memtoReg, regWrite;
    logic             aluSrcA, extOp, pcEn, illegal;
    logic [1:0]       aluSrcB, pcSrc;
    logic [3:0]       aluControl, state;
    logic [CNT_W-1:0] instr_count;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [3:0]       exp_q[$];
    logic [CNT_W-1:0] exp_count = '0;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .regdst(regdst), .memtoReg(memtoReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .extOp(extOp), .aluControl(aluControl),
        .pcSrc(pcSrc), .pcEn(pcEn), .illegal(illegal), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #3;
        n_checks++;
        if (state !== 4'd0 || instr_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d count=%0d, expected 0/0", state, instr_count);
        end
        n_checks++;
        if ({memRead, irWrite, pcEn, regWrite, memWrite} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs: mr/ir/pc/rw/mw=%b expected 10000",
                     {memRead, irWrite, pcEn, regWrite, memWrite});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({state, memRead, irWrite, pcEn} !== {4'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d mr/ir/pc=%b expected 0/111",
                     state, {memRead, irWrite, pcEn});
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        logic [3:0] e;
        opcode = 6'b100011;
        funct  = '0;
        exp_q  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive(1'b1, 1'b0);
            n_checks++;
            if (state !== e) begin
                n_fail++;
                $display("FAIL lw_state: got %0d expected %0d", state, e);
            end
            n_checks++;
            if ({regWrite, memtoReg} !== ((e == 4'd4) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL lw_wb: state %0d regWrite/memtoReg=%b", e, {regWrite, memtoReg});
            end
            if (e == 4'd3) begin
                n_checks++;
                if ({iord, memRead} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL lw_memrd: iord/memRead=%b expected 11", {iord, memRead});
                end
            end
            tick();
        end
        exp_count++;
        n_checks++;
        if (state !== 4'd0 || instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL lw_retire: state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_sw_stall();
        logic       mr_seq[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] e;
        int         cyc = 0;
        int         mw_cycles = 0;
        opcode = 6'b101011;
        exp_q  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive(mr_seq[cyc], 1'b0);
            n_checks++;
            if (state !== e) begin
                n_fail++;
                $display("FAIL sw_state: cycle %0d got %0d expected %0d", cyc, state, e);
            end
            n_checks++;
            if (regWrite !== 1'b0 || (e == 4'd5 && iord !== 1'b1)) begin
                n_fail++;
                $display("FAIL sw_ctrl: cycle %0d regWrite=%b iord=%b", cyc, regWrite, iord);
            end
            if (memWrite === 1'b1) mw_cycles++;
            if (e == 4'd5 && cyc < 6) begin
                n_checks++;
                if (instr_count !== exp_count) begin
                    n_fail++;
                    $display("FAIL sw_early_retire: count=%0d expected %0d", instr_count, exp_count);
                end
            end
            cyc++;
            tick();
        end
        exp_count++;
        n_checks++;
        if (mw_cycles != 4) begin
            n_fail++;
            $display("FAIL sw_memwrite_len: got %0d cycles expected 4", mw_cycles);
        end
        n_checks++;
        if (state !== 4'd0 || instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL sw_retire: state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_beq();
        logic [3:0] e;
        logic       z;
        opcode = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            z     = (k == 0);
            exp_q = '{4'd0, 4'd1, 4'd8};
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                drive(1'b1, z);
                n_checks++;
                if (state !== e) begin
                    n_fail++;
                    $display("FAIL beq_state: zero=%b got %0d expected %0d", z, state, e);
                end
                if (e == 4'd8) begin
                    n_checks++;
                    if ({pcEn, pcSrc, aluControl} !== {z, 2'b01, 4'b0110}) begin
                        n_fail++;
                        $display("FAIL beq_branch: zero=%b pcEn/pcSrc/alu=%b", z, {pcEn, pcSrc, aluControl});
                    end
                end
                tick();
            end
            exp_count++;
            n_checks++;
            if (state !== 4'd0 || instr_count !== exp_count) begin
                n_fail++;
                $display("FAIL beq_retire: state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [3:0] alus[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        logic [3:0] e;
        opcode = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            funct = fns[k];
            exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                drive(1'b1, 1'b0);
                n_checks++;
                if (state !== e) begin
                    n_fail++;
                    $display("FAIL rtype_state: funct=%b got %0d expected %0d", fns[k], state, e);
                end
                if (e == 4'd6) begin
                    n_checks++;
                    if ({aluSrcA, aluSrcB, aluControl} !== {1'b1, 2'b00, alus[k]}) begin
                        n_fail++;
                        $display("FAIL rtype_exec: funct=%b got %b expected %b", fns[k],
                                 {aluSrcA, aluSrcB, aluControl}, {1'b1, 2'b00, alus[k]});
                    end
                end
                if (e == 4'd7) begin
                    n_checks++;
                    if ({regdst, memtoReg, regWrite} !== 3'b101) begin
                        n_fail++;
                        $display("FAIL rtype_wb: regdst/memtoReg/regWrite=%b expected 101",
                                 {regdst, memtoReg, regWrite});
                    end
                end
                tick();
            end
            exp_count++;
        end
        n_checks++;
        if (instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL rtype_count: got %0d expected %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_imm();
        logic [5:0] ops[4]  = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        logic [3:0] alus[4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
        logic       exts[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            exp_q  = '{4'd0, 4'd1, 4'd9, 4'd10};
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                drive(1'b1, 1'b0);
                n_checks++;
                if (state !== e) begin
                    n_fail++;
                    $display("FAIL imm_state: op=%b got %0d expected %0d", ops[k], state, e);
                end
                if (e == 4'd9) begin
                    n_checks++;
                    if ({aluSrcB, aluControl, extOp} !== {2'b10, alus[k], exts[k]}) begin
                        n_fail++;
                        $display("FAIL imm_exec: op=%b srcB/alu/ext=%b expected %b", ops[k],
                                 {aluSrcB, aluControl, extOp}, {2'b10, alus[k], exts[k]});
                    end
                end
                if (e == 4'd10) begin
                    n_checks++;
                    if ({regdst, memtoReg, regWrite} !== 3'b001) begin
                        n_fail++;
                        $display("FAIL imm_wb: regdst/memtoReg/regWrite=%b expected 001",
                                 {regdst, memtoReg, regWrite});
                    end
                end
                tick();
            end
            exp_count++;
        end
        n_checks++;
        if (instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL imm_count: got %0d expected %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_jump_fetch_stall();
        logic       mr_seq[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] e;
        int         cyc = 0;
        opcode = 6'b000010;
        exp_q  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd11};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive(mr_seq[cyc], 1'b0);
            n_checks++;
            if (state !== e) begin
                n_fail++;
                $display("FAIL jump_state: cycle %0d got %0d expected %0d", cyc, state, e);
            end
            if (e == 4'd0) begin
                n_checks++;
                if ({irWrite, pcEn} !== {mr_seq[cyc], mr_seq[cyc]}) begin
                    n_fail++;
                    $display("FAIL fetch_stall: cycle %0d irWrite/pcEn=%b mem_ready=%b",
                             cyc, {irWrite, pcEn}, mr_seq[cyc]);
                end
            end
            if (e == 4'd11) begin
                n_checks++;
                if ({pcSrc, pcEn} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL jump_ctrl: pcSrc/pcEn=%b expected 101", {pcSrc, pcEn});
                end
            end
            cyc++;
            tick();
        end
        exp_count++;
        n_checks++;
        if (state !== 4'd0 || instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL jump_retire: state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[2] = '{6'b111111, 6'b000000};
        logic [5:0] fns[2] = '{6'b100000, 6'b000000};
        logic [3:0] e;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            funct  = fns[k];
            exp_q  = '{4'd0, 4'd1};
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                drive(1'b1, 1'b0);
                n_checks++;
                if (state !== e || illegal !== (e == 4'd1)) begin
                    n_fail++;
                    $display("FAIL illegal_decode: case %0d state=%0d illegal=%b", k, state, illegal);
                end
                n_checks++;
                if ({regWrite, memWrite} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL illegal_writes: case %0d regWrite/memWrite=%b", k, {regWrite, memWrite});
                end
                tick();
            end
            n_checks++;
            if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== exp_count) begin
                n_fail++;
                $display("FAIL illegal_return: state=%0d illegal=%b count=%0d expected 0/0/%0d",
                         state, illegal, instr_count, exp_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic mr_seq[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b100011;
        exp_q  = '{4'd0, 4'd1, 4'd2, 4'd3};
        for (int c = 0; c < 4; c++) begin
            drive(mr_seq[c], 1'b0);
            n_checks++;
            if (state !== exp_q[c]) begin
                n_fail++;
                $display("FAIL midrst_seq: cycle %0d got %0d expected %0d", c, state, exp_q[c]);
            end
            if (c < 3) tick();
        end
        exp_q = '{};
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = '0;
        n_checks++;
        if (state !== 4'd0 || instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL midrst_async: state=%0d count=%0d expected 0/0", state, instr_count);
        end
        n_checks++;
        if ({regWrite, memWrite, irWrite, memRead} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_outputs: rw/mw/ir/mr=%b expected 0001",
                     {regWrite, memWrite, irWrite, memRead});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd0 || instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL midrst_after: state=%0d count=%0d expected 0/0", state, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype();
        test_imm();
        test_jump_fetch_stall();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
